// File: rtl/alu_commit_stage.sv
// ALU commit stage: one-entry pending register, ARM condition check, 8x16 register file and NZCV flags.
// Optional macro ALU_COMMIT_BYPASS_EN forwards pending write data to the read ports.
module alu_commit_stage #(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   alu_out,
    input  logic [3:0]    alu_cond,
    input  logic [3:0]    cond,
    input  logic [AW-1:0] rd,
    input  logic          wr_en,
    input  logic          set_flags,
    input  logic          stall,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [15:0]   ra_data,
    output logic [15:0]   rb_data,
    output logic [3:0]    flags,
    output logic          commit,
    output logic          squash
);

    localparam int DATA_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] data_p0;
    logic [3:0]        ccode_p0;
    logic [3:0]        cond_p0;
    logic [AW-1:0]     rd_p0;
    logic              wr_en_p0;
    logic              set_flags_p0;
    logic              vld_p0;

    logic [DATA_W-1:0] regs [NREGS];

    logic capture;
    logic retire;
    logic pass;

    // Flags are ordered {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = cy;
            4'h3:    r = !cy;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = cy && !z;
            4'h9:    r = !cy || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign vld_p0  = (state == FULL);
    assign capture = in_valid && in_ready;
    assign retire  = vld_p0 && !stall;
    assign pass    = cond_pass(cond_p0, flags);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (capture) state_next = FULL;
            FULL:    if (retire && !capture) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        in_ready = (state == EMPTY) || !stall;
    end

    // Stage p0: pending entry payload; validity lives in the state register.
    always_ff @(posedge clk) begin
        if (capture) begin
            data_p0      <= alu_out;
            ccode_p0     <= alu_cond;
            cond_p0      <= cond;
            rd_p0        <= rd;
            wr_en_p0     <= wr_en;
            set_flags_p0 <= set_flags;
        end
    end

    // Retire: architectural state and the registered commit/squash pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags  <= '0;
            commit <= 1'b0;
            squash <= 1'b0;
        end else begin
            commit <= retire && pass;
            squash <= retire && !pass;
            if (retire && pass) begin
                if (wr_en_p0) regs[rd_p0] <= data_p0;
                if (set_flags_p0) flags <= ccode_p0;
            end
        end
    end

`ifdef ALU_COMMIT_BYPASS_EN
    logic fwd;
    assign fwd = vld_p0 && wr_en_p0 && pass;

    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
        if (fwd && (ra_addr == rd_p0)) ra_data = data_p0;
        if (fwd && (rb_addr == rd_p0)) rb_data = data_p0;
    end
`else
    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
    end
`endif

endmodule

// File: tb/tb_alu_commit_stage.sv
// Randomized and directed bench for alu_commit_stage against an instruction-level reference model.
module tb_alu_commit_stage;

    localparam int AW    = 3;
    localparam int NREGS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   alu_out;
    logic [3:0]    alu_cond;
    logic [3:0]    cond;
    logic [AW-1:0] rd;
    logic          wr_en;
    logic          set_flags;
    logic          stall;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [15:0]   ra_data;
    logic [15:0]   rb_data;
    logic [3:0]    flags;
    logic          commit;
    logic          squash;

    always #10 clk = ~clk;

    alu_commit_stage #(.NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_cond(alu_cond), .cond(cond), .rd(rd),
        .wr_en(wr_en), .set_flags(set_flags), .stall(stall),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .flags(flags), .commit(commit), .squash(squash)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state plus the one in-flight instruction.
    logic [15:0]   m_regs [NREGS];
    logic [3:0]    m_flags;
    logic          m_pv;
    logic [15:0]   m_data;
    logic [3:0]    m_cc;
    logic [3:0]    m_cond;
    logic [AW-1:0] m_rd;
    logic          m_wr;
    logic          m_sf;
    logic          m_commit;
    logic          m_squash;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic arm_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] exp_read(input logic [AW-1:0] a);
        logic [15:0] r;
        r = m_regs[a];
`ifdef ALU_COMMIT_BYPASS_EN
        if (m_pv && m_wr && (a == m_rd) && arm_pass(m_cond, m_flags)) r = m_data;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 16'h0000;
        m_flags  = 4'b0000;
        m_pv     = 1'b0;
        m_commit = 1'b0;
        m_squash = 1'b0;
    endtask

    // Apply the inputs present at the clock edge to the model.
    task automatic model_edge();
        logic ret, cap, ok;
        ret = m_pv && !stall;
        cap = in_valid && (!m_pv || !stall);
        ok  = arm_pass(m_cond, m_flags);
        m_commit = ret && ok;
        m_squash = ret && !ok;
        if (ret && ok) begin
            if (m_wr) m_regs[m_rd] = m_data;
            if (m_sf) m_flags = m_cc;
        end
        if (cap) begin
            m_pv = 1'b1; m_data = alu_out; m_cc = alu_cond; m_cond = cond;
            m_rd = rd; m_wr = wr_en; m_sf = set_flags;
        end else if (ret) begin
            m_pv = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_val("in_ready", in_ready, !m_pv || !stall);
        check_val("flags", flags, m_flags);
        check_val("commit", commit, m_commit);
        check_val("squash", squash, m_squash);
        check_val("ra_data", ra_data, exp_read(ra_addr));
        check_val("rb_data", rb_data, exp_read(rb_addr));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] d, input logic [3:0] cc,
                          input logic [3:0] cn, input logic [AW-1:0] r, input logic w,
                          input logic sf, input logic st);
        in_valid = v; alu_out = d; alu_cond = cc; cond = cn;
        rd = r; wr_en = w; set_flags = sf; stall = st;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 0);
        ra_addr = '0;
        rb_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Unconditional write with flag update.
        set_in(1, 16'h0121, 4'b0000, 4'hE, 3'd2, 1, 1, 0);
        cycle();
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 0);
        ra_addr = 3'd2;
        cycle();
        check_val("t_al_commit", commit, 1'b1);
        check_val("t_al_r2", ra_data, 16'h0121);
        check_val("t_al_flags", flags, 4'b0000);

        // Set Z, then EQ passes and NE is squashed.
        set_in(1, 16'h0000, 4'b0100, 4'hE, 3'd0, 0, 1, 0);
        cycle();
        set_in(1, 16'h00AA, 4'b0000, 4'h0, 3'd3, 1, 0, 0);
        cycle();
        set_in(1, 16'h0055, 4'b0000, 4'h1, 3'd3, 1, 0, 0);
        ra_addr = 3'd3;
        cycle();
        check_val("t_eq_commit", commit, 1'b1);
        check_val("t_eq_r3", ra_data, 16'h00AA);
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 0);
        cycle();
        check_val("t_ne_squash", squash, 1'b1);
        check_val("t_ne_r3", ra_data, 16'h00AA);
        check_val("t_z_flags", flags, 4'b0100);

        // Stall held three cycles while FULL; offered input must not be taken.
        set_in(1, 16'h4444, 4'b0000, 4'hE, 3'd4, 1, 0, 0);
        cycle();
        set_in(1, 16'hDEAD, 4'b0000, 4'hE, 3'd4, 1, 0, 1);
        ra_addr = 3'd4;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t_stall_ready", in_ready, 1'b0);
            check_val("t_stall_nocommit", commit, 1'b0);
        end
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 0);
        cycle();
        check_val("t_stall_commit", commit, 1'b1);
        check_val("t_stall_r4", ra_data, 16'h4444);
        cycle();
        check_val("t_stall_single", commit, 1'b0);

        // Back-to-back stream r0..r7.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 16'h1000 + 16'(i), 4'b0000, 4'hE, AW'(i), 1, 0, 0);
            cycle();
            if (i > 0) check_val("t_stream_commit", commit, 1'b1);
        end
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            ra_addr = AW'(i);
            rb_addr = AW'(7 - i);
            cycle();
            check_val("t_stream_ra", ra_data, 16'h1000 + 16'(i));
            check_val("t_stream_rb", rb_data, 16'h1000 + 16'(7 - i));
        end

        // Pending write to r5 held by stall; read port B before retirement.
        set_in(1, 16'hBEEF, 4'b0000, 4'hE, 3'd5, 1, 0, 0);
        rb_addr = 3'd5;
        cycle();
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 1);
        #2;
`ifdef ALU_COMMIT_BYPASS_EN
        check_val("t_bypass_rb", rb_data, 16'hBEEF);
`else
        check_val("t_nobypass_rb", rb_data, 16'h1005);
`endif
        cycle();
        stall = 1'b0;
        cycle();
        check_val("t_bypass_retired", rb_data, 16'hBEEF);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom), 4'($urandom),
                   AW'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            ra_addr = AW'($urandom);
            rb_addr = AW'($urandom);
            cycle();
        end

        // Reset while an entry is pending.
        set_in(1, 16'h7777, 4'b1111, 4'hE, 3'd1, 1, 1, 0);
        cycle();
        set_in(0, 16'h0, 4'h0, 4'hE, '0, 0, 0, 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("t_rst_ready", in_ready, 1'b1);
        check_val("t_rst_flags", flags, 4'b0000);
        check_val("t_rst_commit", commit, 1'b0);
        check_val("t_rst_squash", squash, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra_addr = AW'(i);
            rb_addr = AW'(7 - i);
            cycle();
            check_val("t_rst_ra", ra_data, 16'h0000);
            check_val("t_rst_rb", rb_data, 16'h0000);
            check_val("t_rst_nocommit", commit, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
